led_afterglow_pwm: RTL and testbench
====================================

# led_afterglow_pwm

Downstream output stage for the LED pattern generator: takes its 8-bit `uo_out` pattern and drives the physical LEDs through per-LED 4-bit PWM with an "afterglow" fade. Any LED whose pattern bit is 1 runs at the programmed peak brightness. Once the bit drops, that LED's brightness decays linearly to off. Knight Rider and LFSR patterns therefore show comet-style trails instead of hard steps.

## Interface
- `DECAY_DIV`, default 256: clk cycles between decay ticks; legal range 1..65535.
- `FADE_STEP`, default 1: brightness decrement per decay tick; legal range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  block enable; 0 freezes all state and forces the outputs low.
- `pattern_in`  in  8  LED pattern from the generator.
- `peak_level`  in  4  brightness applied to lit LEDs; 0 = off, 15 = fully on.
- `pwm_out`  out  8  PWM-modulated LED drive, registered.
- `frame_start`  out  1  one-cycle pulse, registered, high when a new PWM period begins.

## Operation
- Input stage:
  - `pat_q[7:0]` registers `pattern_in` every enabled cycle.
  - `lvl_q[3:0]` registers `peak_level` every enabled cycle.
  - All logic below uses `pat_q` and `lvl_q`.
- PWM counter:
  - `pwm_cnt` counts 0..14 and wraps 14→0, giving a period of 15 cycles.
  - Duty is `bright/15`: `bright=0` is never on and `bright=15` is always on.
- Decay timer:
  - `decay_cnt` is a 16-bit counter that runs 0..DECAY_DIV-1 and then wraps.
  - `tick` = (`decay_cnt == DECAY_DIV-1`).
  - With `DECAY_DIV=1`, `tick` is high on every enabled cycle.
- Brightness registers `bright[i][3:0]`, one per LED, updated each enabled cycle with this priority:
  1. If `pat_q[i]=1`: `bright[i] <= lvl_q`. This applies every cycle, independent of `tick`, so a lit LED tracks `peak_level` changes.
  2. Else if `tick`: `bright[i] <= bright[i] - FADE_STEP`, saturating at 0. Arithmetic uses 5 bits; no underflow wrap is allowed.
  3. Otherwise `bright[i]` holds.
- Outputs:
  - `pwm_out[i] <= ena & (bright[i] > pwm_cnt)`, an unsigned 4-bit compare on current register values.
  - `frame_start <= ena & (pwm_cnt == 0)`.
- When an unlit LED's `bright` already exceeds the new `lvl_q`, it keeps decaying from its current value. It is not clamped to `lvl_q`.
- `ena=0`:
  - `pat_q`, `lvl_q`, `pwm_cnt`, `decay_cnt` and `bright` all hold their values.
  - `pwm_out` and `frame_start` are driven to 0 on the next edge.
  - When `ena` returns, every counter resumes from its held value; nothing restarts.
- No state machine beyond the two counters; each `bright` register acts as a 16-level saturating state per LED.

## Timing
- Reset (async assert, sync release by the system):
  - `pat_q=0`, `lvl_q=0`, `pwm_cnt=0`, `decay_cnt=0`, `bright[*]=0`.
  - `pwm_out=8'h00`, `frame_start=0`.
- Latency:
  - `pattern_in` sampled at edge N → `pat_q` at N.
  - `bright` loaded at N+1.
  - `pwm_out` reflects the new level from edge N+2 onward, within the current PWM period.
- `frame_start`:
  - High for 1 cycle every 15 enabled cycles.
  - Asserted on the edge after the cycle in which `pwm_cnt==0`, i.e. aligned one cycle behind the counter, matching `pwm_out` alignment.
- Full decay from 15 to 0 takes `ceil(15/FADE_STEP)` ticks, i.e. `ceil(15/FADE_STEP)*DECAY_DIV` cycles.
  - Default (FADE_STEP=1, DECAY_DIV=256): 15 ticks = 3840 cycles.
- Simultaneous events:
  - A bit rising on a `tick` cycle: the load wins, and no decrement happens that cycle.
  - A bit falling on a `tick` cycle: the decrement applies on the first tick in which `pat_q[i]=0`.
- Reset mid-fade: all brightness clears immediately (asynchronous); no residual glow.

## Test plan
- **Reset/idle:** assert `rst_n=0` mid-run with `pattern_in=8'hFF`, `peak_level=15` → `pwm_out=8'h00` and `frame_start=0` asynchronously. After release, with `pattern_in=0` held, `pwm_out` stays 00.
- **Steady duty:** `pattern_in=8'h01`, `peak_level=5`, `ena=1` → `pwm_out[0]` is high exactly 5 of every 15 cycles. `frame_start` has period 15. `pwm_out[7:1]=0`.
- **Full/zero level:**
  - `peak_level=15`, `pattern_in=8'hFF` → `pwm_out=8'hFF` constantly.
  - `peak_level=0` → `pwm_out=8'h00` constantly.
- **Afterglow:** `DECAY_DIV=4`, `FADE_STEP=1`, `peak_level=15`. Set `pattern_in=8'h80` and then clear it to 0.
  - `bright[7]` falls 15→14→…→0, one step every 4 cycles (60 cycles).
  - It saturates at 0: no wrap to 15.
  - Duty measured per 15-cycle window decreases monotonically.
- **Saturation with large step:** `FADE_STEP=4`, start level 15 → sequence 11, 7, 3, 0, 0.
- **Enable freeze and tick collision:**
  - Drop `ena` for 20 cycles mid-fade → outputs 0 and `bright` unchanged; on re-enable, the fade continues from the same value.
  - Reassert `pattern_in` bit on a `tick` cycle → `bright` loads `peak_level` with no decrement.

Source files
------------

// File: rtl/led_afterglow_pwm.sv
// LED output stage: per-LED 4-bit PWM with a linear afterglow fade once a pattern bit drops.
module led_afterglow_pwm #(
    parameter int unsigned DECAY_DIV = 256,
    parameter int unsigned FADE_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] pattern_in,
    input  logic [3:0] peak_level,
    output logic [7:0] pwm_out,
    output logic       frame_start
);

    localparam int unsigned NUM_LED = 8;
    localparam int unsigned LVL_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PWM_MAX = 14;

    localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(DECAY_DIV - 1);
    localparam logic [LVL_W-1:0] PWM_LAST   = LVL_W'(PWM_MAX);
    localparam logic [LVL_W:0]   STEP_EXT   = (LVL_W + 1)'(FADE_STEP);

    logic [NUM_LED-1:0]                pat_q, pat_d;
    logic [LVL_W-1:0]                  lvl_q, lvl_d;
    logic [LVL_W-1:0]                  pwm_cnt_q, pwm_cnt_d;
    logic [CNT_W-1:0]                  decay_cnt_q, decay_cnt_d;
    logic [NUM_LED-1:0][LVL_W-1:0]     bright_q, bright_d;
    logic [NUM_LED-1:0]                pwm_out_q, pwm_out_d;
    logic                              frame_start_q, frame_start_d;

    logic                              tick_c;
    logic [NUM_LED-1:0][LVL_W:0]       diff_c;
    logic [NUM_LED-1:0][LVL_W-1:0]     faded_c;

    // Saturating decrement per LED; 5-bit difference exposes the borrow instead of wrapping.
    always_comb begin
        diff_c  = '0;
        faded_c = '0;
        for (int unsigned i = 0; i < NUM_LED; i++) begin
            diff_c[i]  = {1'b0, bright_q[i]} - STEP_EXT;
            faded_c[i] = diff_c[i][LVL_W] ? '0 : diff_c[i][LVL_W-1:0];
        end
    end

    // Next-state for counters, brightness and registered outputs; ena=0 freezes state and idles outputs.
    always_comb begin
        pat_d         = pat_q;
        lvl_d         = lvl_q;
        pwm_cnt_d     = pwm_cnt_q;
        decay_cnt_d   = decay_cnt_q;
        bright_d      = bright_q;
        pwm_out_d     = '0;
        frame_start_d = 1'b0;
        tick_c        = (decay_cnt_q == DECAY_LAST);

        if (ena) begin
            pat_d         = pattern_in;
            lvl_d         = peak_level;
            pwm_cnt_d     = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 4'd1;
            decay_cnt_d   = tick_c ? '0 : decay_cnt_q + 16'd1;
            frame_start_d = (pwm_cnt_q == '0);
            for (int unsigned i = 0; i < NUM_LED; i++) begin
                pwm_out_d[i] = (bright_q[i] > pwm_cnt_q);
                // A lit LED reloads every cycle, so a load always beats a decay tick.
                if (pat_q[i]) begin
                    bright_d[i] = lvl_q;
                end else if (tick_c) begin
                    bright_d[i] = faded_c[i];
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q         <= '0;
            lvl_q         <= '0;
            pwm_cnt_q     <= '0;
            decay_cnt_q   <= '0;
            bright_q      <= '0;
            pwm_out_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pat_q         <= pat_d;
            lvl_q         <= lvl_d;
            pwm_cnt_q     <= pwm_cnt_d;
            decay_cnt_q   <= decay_cnt_d;
            bright_q      <= bright_d;
            pwm_out_q     <= pwm_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pwm_out     = pwm_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_afterglow_pwm.sv
// Bench for led_afterglow_pwm: two parameterisations driven in parallel, checked against a cycle-count model.
module tb_led_afterglow_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] pattern_in;
    logic [3:0] peak_level;
    logic [7:0] pwm_a, pwm_b;
    logic       fs_a, fs_b;

    always #5 clk = ~clk;

    led_afterglow_pwm #(.DECAY_DIV(4), .FADE_STEP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pattern_in(pattern_in),
        .peak_level(peak_level), .pwm_out(pwm_a), .frame_start(fs_a)
    );

    led_afterglow_pwm #(.DECAY_DIV(3), .FADE_STEP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pattern_in(pattern_in),
        .peak_level(peak_level), .pwm_out(pwm_b), .frame_start(fs_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: enabled-edge count replaces the hardware counters.
    int         m_n   [2];
    logic [7:0] m_pat [2];
    int         m_lvl [2];
    int         m_br  [2][8];
    logic [7:0] m_pwm [2];
    logic       m_fs  [2];

    function automatic int div_of(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int step_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k]   = 0;
            m_pat[k] = '0;
            m_lvl[k] = 0;
            m_pwm[k] = '0;
            m_fs[k]  = 1'b0;
            for (int i = 0; i < 8; i++) m_br[k][i] = 0;
        end
    endfunction

    function automatic void model_step();
        int pc;
        bit tick;
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            if (!ena) begin
                m_pwm[k] = '0;
                m_fs[k]  = 1'b0;
            end else begin
                pc   = m_n[k] % 15;
                tick = ((m_n[k] % div_of(k)) == div_of(k) - 1);
                for (int i = 0; i < 8; i++) m_pwm[k][i] = (m_br[k][i] > pc);
                m_fs[k] = (pc == 0);
                for (int i = 0; i < 8; i++) begin
                    if (m_pat[k][i]) m_br[k][i] = m_lvl[k];
                    else if (tick) m_br[k][i] = (m_br[k][i] > step_of(k)) ? m_br[k][i] - step_of(k) : 0;
                end
                m_pat[k] = pattern_in;
                m_lvl[k] = int'(peak_level);
                m_n[k]   = m_n[k] + 1;
            end
        end
    endfunction

    function automatic logic [31:0] pack_br(int k);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(m_br[k][i]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic compare_all();
        check("pwm_a", 32'(pwm_a), 32'(m_pwm[0]));
        check("fs_a", 32'(fs_a), 32'(m_fs[0]));
        check("bright_a", 32'(dut_a.bright_q), pack_br(0));
        check("pwm_b", 32'(pwm_b), 32'(m_pwm[1]));
        check("fs_b", 32'(fs_b), 32'(m_fs[1]));
        check("bright_b", 32'(dut_b.bright_q), pack_br(1));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous assert between edges, two clocks held, release away from the edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_pwm_a", 32'(pwm_a), 32'h0);
        check("rst_async_fs_a", 32'(fs_a), 32'h0);
        check("rst_async_pwm_b", 32'(pwm_b), 32'h0);
        check("rst_async_bright_a", 32'(dut_a.bright_q), 32'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [3:0] lvl;
        int         duty;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ones [8];
        int fcnt;
        int win  [6];
        logic [3:0] last_b;
        logic [3:0] seen_q [$];
        int tries;

        tbl[0] = '{pat: 8'h01, lvl: 4'd5,  duty: 5};
        tbl[1] = '{pat: 8'hFF, lvl: 4'd15, duty: 15};
        tbl[2] = '{pat: 8'hFF, lvl: 4'd0,  duty: 0};
        tbl[3] = '{pat: 8'hA5, lvl: 4'd7,  duty: 7};
        tbl[4] = '{pat: 8'h3C, lvl: 4'd1,  duty: 1};
        tbl[5] = '{pat: 8'h80, lvl: 4'd14, duty: 14};

        rst_n      = 1'b0;
        ena        = 1'b0;
        pattern_in = '0;
        peak_level = '0;
        model_reset();
        #2;
        compare_all();
        cyc();
        rst_n = 1'b1;
        ena   = 1'b1;

        // Idle with no pattern stays dark.
        for (int c = 0; c < 20; c++) cyc();

        // Mid-run reset with everything lit.
        pattern_in = 8'hFF;
        peak_level = 4'd15;
        for (int c = 0; c < 20; c++) cyc();
        pattern_in = 8'h00;
        do_reset();
        for (int c = 0; c < 20; c++) cyc();

        // Steady-state duty per vector over one full PWM period.
        for (int v = 0; v < 6; v++) begin
            pattern_in = tbl[v].pat;
            peak_level = tbl[v].lvl;
            do_reset();
            for (int c = 0; c < 3; c++) cyc();
            for (int i = 0; i < 8; i++) ones[i] = 0;
            fcnt = 0;
            for (int c = 0; c < 15; c++) begin
                cyc();
                for (int i = 0; i < 8; i++) ones[i] += int'(pwm_a[i]);
                fcnt += int'(fs_a);
            end
            for (int i = 0; i < 8; i++)
                check($sformatf("duty_v%0d_led%0d", v, i), 32'(ones[i]),
                      tbl[v].pat[i] ? 32'(tbl[v].duty) : 32'h0);
            check($sformatf("frame_cnt_v%0d", v), 32'(fcnt), 32'd1);
        end

        // Afterglow on LED7: monotone duty per window for step 1, 11/7/3/0 for step 4.
        pattern_in = 8'h80;
        peak_level = 4'd15;
        do_reset();
        for (int c = 0; c < 5; c++) cyc();
        pattern_in = 8'h00;
        last_b = 4'd15;
        seen_q.delete();
        for (int w = 0; w < 6; w++) begin
            win[w] = 0;
            for (int c = 0; c < 15; c++) begin
                cyc();
                win[w] += int'(pwm_a[7]);
                if (dut_b.bright_q[7] != last_b) begin
                    last_b = dut_b.bright_q[7];
                    seen_q.push_back(last_b);
                end
            end
            if (w > 0) begin
                vectors++;
                if (win[w] > win[w-1]) begin
                    miscompares++;
                    $display("FAIL duty_mono_w%0d: got %0d after %0d", w, win[w], win[w-1]);
                end
            end
        end
        check("afterglow_final_window", 32'(win[5]), 32'h0);
        check("afterglow_final_bright", 32'(dut_a.bright_q[7]), 32'h0);
        check("step4_seq_len", 32'(seen_q.size()), 32'd4);
        if (seen_q.size() == 4) begin
            check("step4_seq0", 32'(seen_q[0]), 32'd11);
            check("step4_seq1", 32'(seen_q[1]), 32'd7);
            check("step4_seq2", 32'(seen_q[2]), 32'd3);
            check("step4_seq3", 32'(seen_q[3]), 32'd0);
        end

        // Freeze mid-fade, then resume.
        pattern_in = 8'h80;
        peak_level = 4'd15;
        do_reset();
        for (int c = 0; c < 5; c++) cyc();
        pattern_in = 8'h00;
        for (int c = 0; c < 20; c++) cyc();
        ena = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("freeze_pwm", 32'(pwm_a), 32'h0);
            check("freeze_fs", 32'(fs_a), 32'h0);
        end
        ena = 1'b1;
        for (int c = 0; c < 80; c++) cyc();

        // Bit rises so pat_q is set on a tick cycle: load wins with no decrement.
        pattern_in = 8'h40;
        peak_level = 4'd12;
        for (int c = 0; c < 4; c++) cyc();
        pattern_in = 8'h00;
        for (int c = 0; c < 6; c++) cyc();
        tries = 0;
        while ((m_n[0] % 4) != 2 && tries < 8) begin
            cyc();
            tries++;
        end
        check("tick_align_found", 32'(tries < 8), 32'd1);
        pattern_in = 8'h80;
        peak_level = 4'd9;
        cyc();
        cyc();
        check("tick_collision_load", 32'(dut_a.bright_q[7]), 32'd9);
        cyc();
        check("tick_collision_hold", 32'(dut_a.bright_q[7]), 32'd9);
        pattern_in = 8'h00;

        // Randomised traffic with occasional enable drops, level changes and one reset.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) pattern_in = 8'($urandom);
            if ($urandom_range(0, 19) == 0) peak_level = 4'($urandom);
            if (c == 1000) do_reset();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
